// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-master arbiter for the shared single-port data RAM
//            (LSU = master 0, loader/debug = master 1).
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BE_W       = DATA_W / 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    logic [0:0] r_state;
    logic       r_rr_ptr;
    logic       r_owner;

    logic w_winner;
    logic w_start;
    logic w_rd_phase;
    logic w_win_we;

    always_comb begin
        w_winner = 1'b0;
        if (m0_req && m1_req) begin
            w_winner = (FIXED_PRIO != 0) ? 1'b0 : r_rr_ptr;
        end else if (m1_req) begin
            w_winner = 1'b1;
        end
    end

    // Gating with reset keeps every output low while reset is held.
    assign w_start    = reset && (r_state == IDLE) && (m0_req || m1_req);
    assign w_rd_phase = reset && (r_state == RD_WAIT);
    assign w_win_we   = w_winner ? m1_we : m0_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                r_rr_ptr <= ~w_winner;
                if (!w_win_we) begin
                    r_owner <= w_winner;
                    r_state <= RD_WAIT;
                end
            end
        end else begin
            r_state <= IDLE;
        end
    end

    assign mem_req  = w_start;
    assign mem_we   = w_start && w_win_we;
    assign mem_be   = w_start ? (w_winner ? m1_be : m0_be) : '0;
    assign mem_addr = w_start ? (w_winner ? m1_addr : m0_addr) : '0;
    assign mem_wd   = w_start ? (w_winner ? m1_wd : m0_wd) : '0;

    assign m0_gnt    = w_start && !w_winner;
    assign m1_gnt    = w_start && w_winner;
    assign m0_rvalid = w_rd_phase && !r_owner;
    assign m1_rvalid = w_rd_phase && r_owner;
    assign m0_rd     = m0_rvalid ? mem_rd : '0;
    assign m1_rd     = m1_rvalid ? mem_rd : '0;

    // A read stays stalled through its grant cycle and releases on rvalid.
    assign m0_stall = reset && m0_req && !((m0_gnt && m0_we) || m0_rvalid);
    assign m1_stall = reset && m1_req && !((m1_gnt && m1_we) || m1_rvalid);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance, each
// with its own RAM, checked against a transaction-level reference model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_next;

    logic        req  [2][2];
    logic        we   [2][2];
    logic [3:0]  be   [2][2];
    logic [31:0] addr [2][2];
    logic [31:0] wd   [2][2];
    wire         gnt    [2][2];
    wire         rvalid [2][2];
    wire  [31:0] rd     [2][2];
    wire         stall  [2][2];
    wire         mreq  [2];
    wire         mwe   [2];
    wire  [3:0]  mbe   [2];
    wire  [31:0] maddr [2];
    wire  [31:0] mwd   [2];

    // Reference model state, per instance
    int          pend  [2];
    logic [31:0] pdata [2];
    bit          pref  [2];
    logic [31:0] emem  [2][64];
    bit          act   [2][2];

    int n_cmp = 0;
    int n_err = 0;
    int rand_on = 0;
    int load = 0;
    int drop_pct = 0;
    int fp_m1_cnt = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram [0:63];
        logic [31:0] rd_q;

        initial begin
            for (int i = 0; i < 64; i++) ram[i] = init_word(i);
            rd_q = '0;
        end

        always @(posedge clk) begin
            if (mreq[g]) begin
                if (mwe[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[g][b]) ram[maddr[g][7:2]][8*b +: 8] = mwd[g][8*b +: 8];
                end else begin
                    rd_q = ram[maddr[g][7:2]];
                end
            end
        end

        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4), .FIXED_PRIO(g)) u_dut (
            .clk(clk), .reset(rst_n),
            .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_be(be[g][0]),
            .m0_addr(addr[g][0]), .m0_wd(wd[g][0]),
            .m0_gnt(gnt[g][0]), .m0_rvalid(rvalid[g][0]), .m0_rd(rd[g][0]),
            .m0_stall(stall[g][0]),
            .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_be(be[g][1]),
            .m1_addr(addr[g][1]), .m1_wd(wd[g][1]),
            .m1_gnt(gnt[g][1]), .m1_rvalid(rvalid[g][1]), .m1_rd(rd[g][1]),
            .m1_stall(stall[g][1]),
            .mem_req(mreq[g]), .mem_we(mwe[g]), .mem_be(mbe[g]),
            .mem_addr(maddr[g]), .mem_wd(mwd[g]), .mem_rd(rd_q)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic post(input int d, input int m, input bit w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] b);
        act[d][m]  = 1'b1;
        we[d][m]   = w;
        addr[d][m] = a;
        wd[d][m]   = dat;
        be[d][m]   = b;
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    req[d][m]  = 1'($urandom_range(1));
                    we[d][m]   = 1'($urandom_range(1));
                    addr[d][m] = $urandom;
                    wd[d][m]   = $urandom;
                    be[d][m]   = 4'($urandom_range(15));
                end else begin
                    if (rand_on != 0 && !act[d][m] && $urandom_range(99) < load) begin
                        post(d, m, 1'($urandom_range(1)), {24'h0, 6'($urandom_range(63)), 2'b00},
                             $urandom, 4'($urandom_range(15, 1)));
                    end
                    req[d][m] = act[d][m];
                    // A read owner may withdraw its request while waiting for data.
                    if (act[d][m] && pend[d] == m && !we[d][m] && $urandom_range(99) < drop_pct)
                        req[d][m] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_and_update();
        for (int d = 0; d < 2; d++) begin
            bit          eg [2];
            bit          ev [2];
            bit          es [2];
            logic [31:0] erd [2];
            bit          emreq;
            int          w;
            string       p;
            p = $sformatf("i%0d", d);
            if (!rst_n) begin
                for (int m = 0; m < 2; m++) begin
                    chk({p, "_rst_gnt"}, gnt[d][m], 0);
                    chk({p, "_rst_rvalid"}, rvalid[d][m], 0);
                    chk({p, "_rst_rd"}, rd[d][m], 0);
                    chk({p, "_rst_stall"}, stall[d][m], 0);
                    act[d][m] = 1'b0;
                end
                chk({p, "_rst_mreq"}, mreq[d], 0);
                chk({p, "_rst_mwe"}, mwe[d], 0);
                chk({p, "_rst_mbe"}, mbe[d], 0);
                chk({p, "_rst_maddr"}, maddr[d], 0);
                chk({p, "_rst_mwd"}, mwd[d], 0);
                pend[d] = -1;
                pref[d] = 1'b0;
                continue;
            end
            for (int m = 0; m < 2; m++) begin
                eg[m] = 1'b0; ev[m] = 1'b0; erd[m] = '0;
            end
            emreq = 1'b0;
            w = -1;
            if (pend[d] >= 0) begin
                ev[pend[d]]  = 1'b1;
                erd[pend[d]] = pdata[d];
            end else if (req[d][0] || req[d][1]) begin
                if (req[d][0] && req[d][1]) w = (d == 1) ? 0 : int'(pref[d]);
                else w = req[d][1] ? 1 : 0;
                eg[w] = 1'b1;
                emreq = 1'b1;
            end
            for (int m = 0; m < 2; m++) begin
                es[m] = req[d][m] && !((eg[m] && we[d][m]) || ev[m]);
                chk($sformatf("%s_m%0d_gnt", p, m), gnt[d][m], eg[m]);
                chk($sformatf("%s_m%0d_rvalid", p, m), rvalid[d][m], ev[m]);
                chk($sformatf("%s_m%0d_rd", p, m), rd[d][m], erd[m]);
                chk($sformatf("%s_m%0d_stall", p, m), stall[d][m], es[m]);
            end
            chk({p, "_mreq"}, mreq[d], emreq);
            if (emreq) begin
                chk({p, "_mwe"}, mwe[d], we[d][w]);
                chk({p, "_mbe"}, mbe[d], be[d][w]);
                chk({p, "_maddr"}, maddr[d], addr[d][w]);
                chk({p, "_mwd"}, mwd[d], wd[d][w]);
            end
            if (d == 1 && gnt[1][1] === 1'b1) fp_m1_cnt++;
            if (pend[d] >= 0) begin
                pend[d] = -1;
            end else if (w >= 0) begin
                pref[d] = (w == 0);
                if (we[d][w]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[d][w][b]) emem[d][addr[d][w][7:2]][8*b +: 8] = wd[d][w][8*b +: 8];
                end else begin
                    pend[d]  = w;
                    pdata[d] = emem[d][addr[d][w][7:2]];
                end
            end
            for (int m = 0; m < 2; m++)
                if (act[d][m] && ((we[d][m] && eg[m]) || (!we[d][m] && ev[m])))
                    act[d][m] = 1'b0;
        end
    endtask

    task automatic cyc_start();
        @(negedge clk);
        rst_n = rst_next;
        drive();
        #2;
        check_and_update();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        cyc_start();
        cyc_end();
    endtask

    task automatic do_reset(input int n);
        rst_next = 1'b0;
        repeat (n) cycle();
        rst_next = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rst_next = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = -1; pdata[d] = '0; pref[d] = 1'b0;
            for (int i = 0; i < 64; i++) emem[d][i] = init_word(i);
            for (int m = 0; m < 2; m++) begin
                act[d][m] = 1'b0; req[d][m] = 1'b0; we[d][m] = 1'b0;
                be[d][m] = '0; addr[d][m] = '0; wd[d][m] = '0;
            end
        end

        do_reset(3);

        // Single read after reset
        for (int d = 0; d < 2; d++) post(d, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        cyc_start();
        chk("t1_gnt", gnt[0][0], 1);
        chk("t1_addr", maddr[0], 32'h10);
        cyc_end();
        cyc_start();
        chk("t1_rd", rd[0][0], 32'hDEADBEEF);
        chk("t1_stall", stall[0][0], 0);
        cyc_end();

        // Write, then read back
        for (int d = 0; d < 2; d++) post(d, 0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        cyc_start();
        chk("t2_mwe", mwe[0], 1);
        chk("t2_stall", stall[0][0], 0);
        cyc_end();
        for (int d = 0; d < 2; d++) post(d, 0, 1'b0, 32'h20, 32'h0, 4'h0);
        cycle();
        cyc_start();
        chk("t2_rd", rd[0][0], 32'h12345678);
        cyc_end();

        // Continuous writes from both masters: round-robin alternation
        do_reset(2);
        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < 2; m++)
                    if (!act[d][m]) post(d, m, 1'b1, 32'h80 + 32'(k * 8 + m * 4), $urandom, 4'hF);
            cyc_start();
            chk("t3_alt_m0", gnt[0][0], (k % 2) == 0);
            chk("t3_loser_stall", stall[0][(k % 2) == 0 ? 1 : 0], 1);
            cyc_end();
        end

        // Both masters read
        do_reset(2);
        for (int d = 0; d < 2; d++) begin
            post(d, 0, 1'b0, 32'h08, 32'h0, 4'h0);
            post(d, 1, 1'b0, 32'h0C, 32'h0, 4'h0);
        end
        cyc_start(); chk("t4_t0_gnt0", gnt[0][0], 1); chk("t4_t0_stall1", stall[0][1], 1); cyc_end();
        cyc_start(); chk("t4_t1_rv0", rvalid[0][0], 1); chk("t4_t1_stall1", stall[0][1], 1); cyc_end();
        cyc_start(); chk("t4_t2_gnt1", gnt[0][1], 1); chk("t4_t2_stall1", stall[0][1], 1); cyc_end();
        cyc_start(); chk("t4_t3_rd1", rd[0][1], init_word(3)); chk("t4_t3_stall1", stall[0][1], 0); cyc_end();

        // Fixed priority: m0 never lets go, m1 must starve
        do_reset(2);
        fp_m1_cnt = 0;
        for (int d = 0; d < 2; d++) post(d, 1, 1'b0, 32'h30, 32'h0, 4'h0);
        for (int k = 0; k < 12; k++) begin
            for (int d = 0; d < 2; d++)
                if (!act[d][0]) post(d, 0, 1'b1, 32'h40, 32'(k), 4'h3);
            cycle();
        end
        chk("t4_fp_m1_starved", fp_m1_cnt, 0);

        // Request withdrawn while waiting for read data
        do_reset(2);
        for (int d = 0; d < 2; d++) post(d, 1, 1'b0, 32'h24, 32'h0, 4'h0);
        drop_pct = 100;
        cyc_start(); chk("t5_gnt1", gnt[0][1], 1); cyc_end();
        cyc_start();
        chk("t5_rv1", rvalid[0][1], 1);
        chk("t5_rd1", rd[0][1], init_word(9));
        chk("t5_rv0", rvalid[0][0], 0);
        cyc_end();
        drop_pct = 0;

        // Reset while a read is outstanding
        for (int d = 0; d < 2; d++) post(d, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle();
        rst_next = 1'b0;
        cyc_start(); chk("t6_rv_dropped", rvalid[0][0], 0); cyc_end();
        cycle();
        rst_next = 1'b1;
        for (int d = 0; d < 2; d++) begin
            post(d, 0, 1'b1, 32'h50, 32'hCAFE0000, 4'hF);
            post(d, 1, 1'b1, 32'h54, 32'hCAFE0001, 4'hF);
        end
        cyc_start();
        chk("t6_gnt0", gnt[0][0], 1);
        chk("t6_gnt1", gnt[0][1], 0);
        cyc_end();

        // Randomized traffic with occasional read withdrawal and resets
        rand_on = 1;
        load = 60;
        drop_pct = 20;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(299) == 0) do_reset(2);
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter sharing the single-port data RAM between the RISC-V core LSU (master 0) and a loader/debug port (master 1, used for RAM preload and result readback).
Round-robin or fixed priority, one transaction at a time.
Sits in top_RiscV between core/LSU, loader and RAM.
RAM has fixed 1-cycle read latency; writes commit at the clock edge of the grant cycle.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
BE_W, DATA_W/8, byte-enable width
FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins contention

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
m0_req / m1_req  in  1  transaction request from master N
m0_we / m1_we  in  1  1 = write, 0 = read
m0_be / m1_be  in  BE_W  byte enables (writes only)
m0_addr / m1_addr  in  ADDR_W  byte address
m0_wd / m1_wd  in  DATA_W  write data
m0_gnt / m1_gnt  out  1  request accepted this cycle
m0_rvalid / m1_rvalid  out  1  read data valid this cycle
m0_rd / m1_rd  out  DATA_W  read data
m0_stall / m1_stall  out  1  master must hold its request (drives core PC enable)
mem_req  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_be  out  BE_W  RAM byte enables
mem_addr  out  ADDR_W  RAM address
mem_wd  out  DATA_W  RAM write data
mem_rd  in  DATA_W  RAM read data, valid 1 cycle after a read mem_req

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0 (master 0 preferred), owner=0.
  - All outputs 0 while reset is low.
- Master rule: hold req/we/be/addr/wd stable until gnt (write) or rvalid (read).
- States: IDLE, RD_WAIT.
- IDLE, winner selection:
  - Only one master requesting: that master wins.
  - Both requesting: FIXED_PRIO=1 -> master 0; otherwise master rr_ptr.
- IDLE, outputs in the same cycle (combinational from inputs + state):
  - mem_req=1; mem_we/be/addr/wd = winner's fields; winner gnt=1; loser gnt=0.
- IDLE, at the clock edge:
  - rr_ptr <= ~winner.
  - Winner write: stay IDLE; RAM commits at this edge.
  - Winner read: owner <= winner; go to RD_WAIT.
- RD_WAIT:
  - mem_req=0; no grants.
  - owner rvalid=1, owner rd=mem_rd; return to IDLE.
- rd is 0 whenever that master's rvalid=0. rvalid is never asserted for writes.
- Latency: write = 1 cycle (gnt cycle). Read = 2 cycles (gnt, then rvalid). Back-to-back reads: 1 every 2 cycles. Back-to-back writes: 1 per cycle.
- Stall: mN_stall = mN_req & ~((mN_gnt & mN_we) | mN_rvalid).
  - A read is stalled in both its gnt cycle and any losing cycles.
  - A read is unstalled in its rvalid cycle.
- Starvation bound, round-robin: a waiting master is granted after at most one transaction of the other master.
- Request withdrawn in RD_WAIT: rvalid still pulses for the latched owner.
- Idle: no requests -> mem_req=0, rr_ptr unchanged.
- Reset mid-read: returns to IDLE immediately; the pending rvalid is dropped.
- No address decode or alignment check; addresses pass through (LSU handles alignment).

Test Plan:
1. Reset low 3 cycles, then high:
   - All outputs 0 during reset.
   - m0 read 0x10 with RAM[0x10]=0xDEADBEEF -> cycle 0: m0_gnt=1, mem_addr=0x10; cycle 1: m0_rvalid=1, m0_rd=0xDEADBEEF, m0_stall=0.
2. m0 write 0x20 data 0x12345678 be=4'b1111 -> same cycle: m0_gnt=1, mem_we=1, m0_stall=0; subsequent read of 0x20 returns 0x12345678.
3. Both masters issue writes continuously, FIXED_PRIO=0:
   - Grants alternate m0, m1, m0, m1 (rr_ptr starts at 0).
   - Each loser has stall=1 in its losing cycle.
4. Both masters read, FIXED_PRIO=0:
   - m0 gnt at t0, rvalid at t1; m1 gnt at t2, rvalid at t3.
   - m1_stall=1 in t0..t2.
   - With FIXED_PRIO=1 and m0 requesting continuously, m1 is never granted.
5. m1 read granted, then m1_req dropped in RD_WAIT -> m1_rvalid=1 with correct data; m0_rvalid stays 0.
6. Reset asserted in RD_WAIT -> no rvalid; after release, state=IDLE and m0 wins the next contention.
